// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue sitting between IMEM and Decode.
// Owns the fetch PC, issues sequential word requests to an in-order,
// variable-latency IMEM port, buffers returned words with their PC/PC+4 and
// hands them to Decode over a valid/ready handshake. Execute2 redirects
// flush the queue; responses to requests already in flight are dropped
// through a discard counter.
// Optional feature macro: IFQ_BYPASS_EN (response-to-decode bypass when the
// head entry is still waiting for its data).
module ifetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            instr_ready
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] WORD_0   = {XLEN{1'b0}};

  // New discard count on a redirect: everything still unfilled becomes
  // stale, minus a response that is being dropped in the redirect cycle.
  // Never goes below zero.
  function automatic logic [CW-1:0] redirect_discard(
    input logic [CW-1:0] disc,
    input logic [CW-1:0] pend,
    input logic          rsp
  );
    logic [CW:0] sum;
    sum = {1'b0, disc} + {1'b0, pend};
    if (rsp && (sum != {(CW+1){1'b0}})) begin
      sum = sum - {{CW{1'b0}}, 1'b1};
    end else begin
      sum = sum;
    end
    return sum[CW-1:0];
  endfunction

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   alloc_q, alloc_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   occ_q, occ_d;     // allocated entries
  logic [CW-1:0]   pend_q, pend_d;   // allocated but not yet filled
  logic [CW-1:0]   disc_q, disc_d;   // responses still to be dropped
  logic [XLEN-1:0] ent_pc_q   [DEPTH];
  logic [XLEN-1:0] ent_pc_d   [DEPTH];
  logic [XLEN-1:0] ent_pc4_q  [DEPTH];
  logic [XLEN-1:0] ent_pc4_d  [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];
  logic [XLEN-1:0] ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

  // Per-cycle decisions
  logic occ_full_s;
  logic head_filled_s;
  logic req_valid_s;
  logic alloc_s;
  logic rsp_keep_s;
  logic rsp_drop_s;
  logic bypass_s;
  logic head_valid_s;
  logic pop_s;

  // Decide request, response handling and pop for the current cycle
  always_comb begin
    occ_full_s    = (occ_q == CNT_FULL);
    head_filled_s = ent_filled_q[head_q];
    req_valid_s   = !rst && !redirect_valid && !occ_full_s;
    alloc_s       = req_valid_s && imem_req_ready;
    rsp_keep_s    = imem_rsp_valid && !redirect_valid &&
                    (disc_q == CNT_ZERO) && (pend_q != CNT_ZERO);
    rsp_drop_s    = imem_rsp_valid && !redirect_valid && (disc_q != CNT_ZERO);
`ifdef IFQ_BYPASS_EN
    // In-order IMEM: with the head unfilled, the kept response is the head's.
    bypass_s      = rsp_keep_s && !head_filled_s;
`else
    bypass_s      = 1'b0;
`endif
    head_valid_s  = head_filled_s || bypass_s;
    pop_s         = head_valid_s && instr_ready && !redirect_valid;
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;

  // Present the head entry to Decode
  always_comb begin
    instr_valid    = head_valid_s;
    instr_pc       = ent_pc_q[head_q];
    instr_pc_plus4 = ent_pc4_q[head_q];
`ifdef IFQ_BYPASS_EN
    if (bypass_s) begin
      instr = imem_rsp_data;
    end else begin
      instr = ent_data_q[head_q];
    end
`else
    instr          = ent_data_q[head_q];
`endif
  end

  // Next-state computation: redirect flush, else pop / fill / allocate
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    head_d       = head_q;
    alloc_d      = alloc_q;
    fill_d       = fill_q;
    occ_d        = occ_q;
    pend_d       = pend_q;
    disc_d       = disc_q;
    ent_pc_d     = ent_pc_q;
    ent_pc4_d    = ent_pc4_q;
    ent_data_d   = ent_data_q;
    ent_filled_d = ent_filled_q;

    if (redirect_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_d[i]   = WORD_0;
        ent_pc4_d[i]  = WORD_0;
        ent_data_d[i] = WORD_0;
      end
      ent_filled_d = {DEPTH{1'b0}};
      alloc_d      = head_q;
      fill_d       = head_q;
      occ_d        = CNT_ZERO;
      pend_d       = CNT_ZERO;
      disc_d       = redirect_discard(disc_q, pend_q, imem_rsp_valid);
      fetch_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      // Consume the head; the slot is cleared so idle entries read as zero.
      if (pop_s) begin
        ent_pc_d[head_q]     = WORD_0;
        ent_pc4_d[head_q]    = WORD_0;
        ent_data_d[head_q]   = WORD_0;
        ent_filled_d[head_q] = 1'b0;
        head_d               = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end

      // Kept responses fill in order; a bypassed-and-popped word is never stored.
      if (rsp_keep_s) begin
        if (!(bypass_s && pop_s)) begin
          ent_data_d[fill_q]   = imem_rsp_data;
          ent_filled_d[fill_q] = 1'b1;
        end else begin
          ent_filled_d[fill_q] = 1'b0;
        end
        fill_d = fill_q + PTR_ONE;
      end else if (rsp_drop_s) begin
        disc_d = disc_q - CNT_ONE;
      end else begin
        fill_d = fill_q;
      end

      if (alloc_s) begin
        ent_pc_d[alloc_q]     = fetch_pc_q;
        ent_pc4_d[alloc_q]    = fetch_pc_q + PC_STEP;
        ent_data_d[alloc_q]   = WORD_0;
        ent_filled_d[alloc_q] = 1'b0;
        alloc_d               = alloc_q + PTR_ONE;
        fetch_pc_d            = fetch_pc_q + PC_STEP;
      end else begin
        alloc_d = alloc_q;
      end

      occ_d  = occ_q + CW'(alloc_s) - CW'(pop_s);
      pend_d = pend_q + CW'(alloc_s) - CW'(rsp_keep_s);
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      head_q       <= {PW{1'b0}};
      alloc_q      <= {PW{1'b0}};
      fill_q       <= {PW{1'b0}};
      occ_q        <= CNT_ZERO;
      pend_q       <= CNT_ZERO;
      disc_q       <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= WORD_0;
        ent_pc4_q[i]  <= WORD_0;
        ent_data_q[i] <= WORD_0;
      end
      ent_filled_q <= {DEPTH{1'b0}};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      head_q       <= head_d;
      alloc_q      <= alloc_d;
      fill_q       <= fill_d;
      occ_q        <= occ_d;
      pend_q       <= pend_d;
      disc_q       <= disc_d;
      ent_pc_q     <= ent_pc_d;
      ent_pc4_q    <= ent_pc4_d;
      ent_data_q   <= ent_data_d;
      ent_filled_q <= ent_filled_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model and an IMEM
// emulation with in-order, variable-latency responses.
`timescale 1ns/1ps
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
  localparam int FILL_LAT = 1;
`else
  localparam int FILL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .instr_ready(instr_ready)
  );

  typedef struct { logic [31:0] addr; int due; } imreq_t;
  typedef struct { logic [31:0] pc; bit filled; } ent_t;

  imreq_t      imq[$];     // IMEM requests in flight
  ent_t        mq[$];      // model queue contents, oldest first
  int          m_disc = 0;
  logic [31:0] m_fetch = RESET_PC;
  int          cyc = 0;
  bit          armed = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          last_due = 0;

  bit          log_rv[$], log_acc[$], log_iv[$], log_pop[$];
  logic [31:0] log_ra[$], log_ip[$], log_i[$], log_ip4[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive IMEM response, compare at negedge, advance model.
  task automatic run_cycle();
    bit e_rv, byp, e_iv, pop;
    int unf, k, d;
    if (!rst && imq.size() > 0 && imq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(imq[0].addr);
      void'(imq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    @(negedge clk);
    e_rv = !rst && !redirect_valid && (mq.size() < DEPTH);
    byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp  = imem_rsp_valid && !redirect_valid && m_disc == 0 && mq.size() > 0 && !mq[0].filled;
`endif
    e_iv = (mq.size() > 0 && mq[0].filled) || byp;
    log_rv.push_back(imem_req_valid);
    log_ra.push_back(imem_req_addr);
    log_acc.push_back(imem_req_valid && imem_req_ready);
    log_iv.push_back(instr_valid);
    log_pop.push_back(instr_valid && instr_ready && !redirect_valid);
    log_ip.push_back(instr_pc);
    log_i.push_back(instr);
    log_ip4.push_back(instr_pc_plus4);
    if (armed) begin
      chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) chk("req_addr", imem_req_addr, m_fetch);
      if (!rst) begin
        chk("instr_valid", 32'(instr_valid), 32'(e_iv));
        if (e_iv) begin
          chk("instr_pc", instr_pc, mq[0].pc);
          chk("instr_pc_plus4", instr_pc_plus4, mq[0].pc + 32'd4);
          chk("instr", instr, memf(mq[0].pc));
        end
      end
    end
    // reference model update (and IMEM emulation)
    if (rst) begin
      mq.delete();
      imq.delete();
      m_disc   = 0;
      m_fetch  = RESET_PC;
      last_due = cyc;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        imq.push_back('{imem_req_addr, d});
      end
      if (redirect_valid) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        m_disc = m_disc + unf - (imem_rsp_valid ? 1 : 0);
        if (m_disc < 0) m_disc = 0;
        mq.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        pop = e_iv && instr_ready;
        if (imem_rsp_valid) begin
          if (m_disc > 0) m_disc--;
          else begin
            k = -1;
            foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
            if (k >= 0) mq[k].filled = 1'b1;
          end
        end
        if (pop) void'(mq.pop_front());
        if (e_rv && imem_req_ready) begin
          mq.push_back('{m_fetch, 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    armed = armed || rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic first_iv(input int from, input string nm, input logic [31:0] pc_exp);
    int k;
    k = -1;
    for (int c = from; c < log_iv.size(); c++) if (k < 0 && log_iv[c]) k = c;
    if (k < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no instruction delivered, expected pc %h", nm, pc_exp);
    end else begin
      chk({nm, "_pc"}, log_ip[k], pc_exp);
      chk({nm, "_data"}, log_i[k], memf(pc_exp));
    end
  endtask

  function automatic int count_acc(input int from, input int n);
    int c;
    c = 0;
    for (int i = from; i < from + n; i++) if (log_acc[i]) c++;
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int s, s2, k, np;
    logic [31:0] exp5 [5];
    exp5 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state and streaming with 1-cycle IMEM
    run_cycle(); run_cycle();
    chk("rst_req_valid", 32'(log_rv[1]), 32'h0);
    chk("rst_instr_valid", 32'(log_iv[1]), 32'h0);
    chk("rst_instr", log_i[1], 32'h0);
    chk("rst_instr_pc", log_ip[1], 32'h0);
    chk("rst_instr_pc_plus4", log_ip4[1], 32'h0);
    s = cyc; rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (14) run_cycle();
    chk("t1_addr0", log_ra[s], 32'h0);
    chk("t1_addr1", log_ra[s+1], 32'h4);
    chk("t1_addr2", log_ra[s+2], 32'h8);
    chk("t1_first_valid", 32'(log_iv[s+FILL_LAT]), 32'h1);
    chk("t1_first_pc", log_ip[s+FILL_LAT], 32'h0);
    chk("t1_first_pc4", log_ip4[s+FILL_LAT], 32'h4);
    chk("t1_second_pc", log_ip[s+FILL_LAT+1], 32'h4);
    np = 0;
    for (int i = s + FILL_LAT; i < s + FILL_LAT + 10; i++) if (log_iv[i]) np++;
    chk("t1_throughput", 32'(np), 32'd10);

    // Decode stall fills the queue, then drains in order
    do_reset();
    instr_ready = 1'b0; s = cyc;
    repeat (10) run_cycle();
    chk("t2_accepted", 32'(count_acc(s, 10)), 32'd4);
    chk("t2_full_valid", 32'(log_rv[s+4]), 32'h0);
    chk("t2_full_valid_late", 32'(log_rv[s+9]), 32'h0);
    instr_ready = 1'b1; s2 = cyc;
    repeat (12) run_cycle();
    k = 0;
    for (int i = s2; i < log_pop.size(); i++) begin
      if (log_pop[i] && k < 5) begin
        chk("t2_order", log_ip[i], exp5[k]);
        k++;
      end
    end
    chk("t2_pops", 32'(k), 32'd5);
    k = -1;
    for (int i = s2; i < log_acc.size(); i++) if (k < 0 && log_acc[i]) k = i;
    if (k < 0) begin n_cmp++; n_bad++; $display("FAIL t2_resume: no request after release"); end
    else chk("t2_resume_addr", log_ra[k], 32'h10);

    // Redirect with two requests outstanding on a 3-cycle IMEM
    lat_min = 3; lat_max = 3;
    do_reset();
    s = cyc;
    run_cycle(); run_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    run_cycle();
    redirect_valid = 1'b0;
    repeat (12) run_cycle();
    chk("t3_req_valid", 32'(log_rv[s+3]), 32'h1);
    chk("t3_req_addr", log_ra[s+3], 32'h100);
    first_iv(s, "t3_first", 32'h100);

    // Back-to-back redirects with three responses in flight
    do_reset();
    s = cyc;
    repeat (3) run_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    run_cycle();
    redirect_pc = 32'h0000_0300;
    run_cycle();
    redirect_valid = 1'b0;
    repeat (12) run_cycle();
    chk("t4_req_addr", log_ra[s+5], 32'h300);
    first_iv(s, "t4_first", 32'h300);

    // Reset while full and stalled
    lat_min = 1; lat_max = 1;
    do_reset();
    instr_ready = 1'b0;
    repeat (8) run_cycle();
    s = cyc;
    chk("t5_full_before", 32'(log_rv[s-1]), 32'h0);
    rst = 1'b1; run_cycle();
    rst = 1'b0; run_cycle();
    chk("t5_instr_valid", 32'(log_iv[s+1]), 32'h0);
    chk("t5_req_addr", log_ra[s+1], RESET_PC);
    chk("t5_req_valid", 32'(log_rv[s+1]), 32'h1);

`ifdef IFQ_BYPASS_EN
    // Bypass: response goes straight to Decode, queue ends empty
    do_reset();
    instr_ready = 1'b1; imem_req_ready = 1'b1; s = cyc;
    run_cycle();
    imem_req_ready = 1'b0;
    run_cycle(); run_cycle();
    chk("t6_bypass_valid", 32'(log_iv[s+1]), 32'h1);
    chk("t6_bypass_pc", log_ip[s+1], 32'h0);
    chk("t6_bypass_data", log_i[s+1], memf(32'h0));
    instr_ready = 1'b0; imem_req_ready = 1'b1; s = cyc;
    repeat (8) run_cycle();
    chk("t6_empty_after", 32'(count_acc(s, 8)), 32'd4);
`endif

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready    = ((i / 200) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom();
      run_cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
